obstacle_scheduler: RTL and testbench

OBSTACLE_SCHEDULER -- requirements
Module: obstacle_scheduler

---
 rtl/obstacle_scheduler.sv | 158 +++++++++++++++
 tb/tb_obstacle_scheduler.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: three-slot obstacle spawner and scroller for a side-scrolling game.
// Optional build macro: OBSTACLE_SPEEDUP_EN enables a difficulty ramp that shrinks the spawn gap.
//
// Parameters:
//   SPAWN_X    x position given to a newly spawned obstacle
//   MIN_GAP    base minimum number of scroll steps between spawns
//   GAP_FLOOR  smallest minimum gap the difficulty ramp can reach
//
// Ports:
//   clk             system clock, single domain
//   sys_rst         asynchronous active-high reset
//   game_rst        synchronous game restart pulse
//   start           level, leaves IDLE when high
//   halt            level, freezes scheduling while high
//   step            one-cycle pulse per scrolled pixel
//   rand_val        free-running random byte, sampled on spawn
//                   (named rand_val because "rand" is a reserved word)
//   obstacle_active per-slot valid bits
//   obstacle_type   per-slot type, 0 = ION crossing, 1 = UW emblem
//   obstacle_x      three packed 10-bit x positions, slot 0 in [9:0]
//   spawn_pulse     registered one-cycle pulse after every spawn

module obstacle_scheduler #(
    parameter logic [9:0] SPAWN_X   = 10'd639,
    parameter logic [9:0] MIN_GAP   = 10'd160,
    parameter logic [9:0] GAP_FLOOR = 10'd64
) (
    input  logic        clk,
    input  logic        sys_rst,
    input  logic        game_rst,
    input  logic        start,
    input  logic        halt,
    input  logic        step,
    input  logic [7:0]  rand_val,
    output logic [2:0]  obstacle_active,
    output logic [2:0]  obstacle_type,
    output logic [29:0] obstacle_x,
    output logic        spawn_pulse
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [2:0][9:0]  x_q;
    logic [9:0]       gap_cnt;
    logic [9:0]       cur_gap;
    logic [9:0]       reload;
    logic [2:0]       free_oh;
    logic             advance;
    logic             do_spawn;

    // FSM state register
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= IDLE;
        end else if (game_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (halt)  next_state = FROZEN;
            FROZEN:  if (!halt) next_state = RUN;
            default: next_state = IDLE;
        endcase
    end

    // A step only counts while running and not being halted this very cycle,
    // so that a halt takes effect immediately rather than one step late.
    always_comb begin
        advance  = (state == RUN) && !halt && step;
        // lowest clear bit of the active mask; zero when all slots are busy
        free_oh  = ~obstacle_active & (obstacle_active + 3'd1);
        do_spawn = advance && (gap_cnt == 10'd0) && (free_oh != 3'd0);
        reload   = cur_gap + {3'b000, rand_val[7:1]};
    end

    // Slots, gap counter and spawn pulse
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            obstacle_active <= '0;
            obstacle_type   <= '0;
            x_q             <= '0;
            gap_cnt         <= MIN_GAP;
            spawn_pulse     <= 1'b0;
        end else if (game_rst) begin
            obstacle_active <= '0;
            obstacle_type   <= '0;
            x_q             <= '0;
            gap_cnt         <= MIN_GAP;
            spawn_pulse     <= 1'b0;
        end else begin
            spawn_pulse <= do_spawn;
            if (advance) begin
                for (int i = 0; i < 3; i++) begin
                    if (do_spawn && free_oh[i]) begin
                        obstacle_active[i] <= 1'b1;
                        obstacle_type[i]   <= rand_val[0];
                        x_q[i]             <= SPAWN_X;
                    end else if (obstacle_active[i]) begin
                        // reaching x==0 and stepping again retires the slot;
                        // x and type are left as they were
                        if (x_q[i] == 10'd0) begin
                            obstacle_active[i] <= 1'b0;
                        end else begin
                            x_q[i] <= x_q[i] - 10'd1;
                        end
                    end
                end
                if (do_spawn) begin
                    gap_cnt <= reload;
                end else if (gap_cnt != 10'd0) begin
                    gap_cnt <= gap_cnt - 10'd1;
                end
            end
        end
    end

`ifdef OBSTACLE_SPEEDUP_EN
    logic [3:0] spawn_cnt;

    // Every 16th spawn tightens the gap by 16, never below GAP_FLOOR.
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            spawn_cnt <= '0;
            cur_gap   <= MIN_GAP;
        end else if (game_rst) begin
            spawn_cnt <= '0;
            cur_gap   <= MIN_GAP;
        end else if (do_spawn) begin
            spawn_cnt <= spawn_cnt + 4'd1;
            if (spawn_cnt == 4'hf) begin
                if (cur_gap >= GAP_FLOOR + 10'd16) begin
                    cur_gap <= cur_gap - 10'd16;
                end else begin
                    cur_gap <= GAP_FLOOR;
                end
            end
        end
    end
`else
    assign cur_gap = MIN_GAP;
`endif

    assign obstacle_x = x_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// tb_obstacle_scheduler: self-checking bench for obstacle_scheduler.
// Compares the DUT with a slot-level behavioural model under directed and random stimulus.

module tb_obstacle_scheduler;

    logic        clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        game_rst = 1'b0;
    logic        start = 1'b0;
    logic        halt = 1'b0;
    logic        step = 1'b0;
    logic [7:0]  rnd = 8'd0;
    logic [2:0]  obstacle_active;
    logic [2:0]  obstacle_type;
    logic [29:0] obstacle_x;
    logic        spawn_pulse;

    int checks = 0;
    int passes = 0;
    int fail_prints = 0;

    // behavioural model: 0 = idle, 1 = run, 2 = frozen
    bit m_act[3];
    int m_x[3];
    bit m_typ[3];
    int m_gap;
    int m_cur;
    int m_nsp;
    int m_st;
    bit m_sp;

    obstacle_scheduler dut (
        .clk(clk),
        .sys_rst(sys_rst),
        .game_rst(game_rst),
        .start(start),
        .halt(halt),
        .step(step),
        .rand_val(rnd),
        .obstacle_active(obstacle_active),
        .obstacle_type(obstacle_type),
        .obstacle_x(obstacle_x),
        .spawn_pulse(spawn_pulse)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_act[i] = 0;
            m_x[i] = 0;
            m_typ[i] = 0;
        end
        m_gap = 160;
        m_cur = 160;
        m_nsp = 0;
        m_st = 0;
        m_sp = 0;
    endtask

    task automatic model_clk();
        bit adv;
        int f;
        bit sp;
        if (game_rst) begin
            model_reset();
            return;
        end
        adv = (m_st == 1) && !halt && step;
        sp = 0;
        if (adv) begin
            f = -1;
            for (int i = 2; i >= 0; i--) if (!m_act[i]) f = i;
            sp = (m_gap == 0) && (f >= 0);
            for (int i = 0; i < 3; i++) begin
                if (m_act[i]) begin
                    if (m_x[i] == 0) m_act[i] = 0;
                    else m_x[i] = m_x[i] - 1;
                end
            end
            if (sp) begin
                m_act[f] = 1;
                m_x[f] = 639;
                m_typ[f] = rnd[0];
                m_gap = m_cur + int'(rnd[7:1]);
                m_nsp++;
`ifdef OBSTACLE_SPEEDUP_EN
                if (m_nsp % 16 == 0)
                    m_cur = (m_cur - 16 < 64) ? 64 : m_cur - 16;
`endif
            end else if (m_gap > 0) begin
                m_gap = m_gap - 1;
            end
        end
        m_sp = sp;
        case (m_st)
            0: if (start) m_st = 1;
            1: if (halt) m_st = 2;
            2: if (!halt) m_st = 1;
            default: m_st = 0;
        endcase
    endtask

    function automatic logic [29:0] ex_x();
        logic [29:0] v;
        for (int i = 0; i < 3; i++) v[i*10 +: 10] = 10'(m_x[i]);
        return v;
    endfunction

    function automatic logic [2:0] ex_act();
        logic [2:0] v;
        for (int i = 0; i < 3; i++) v[i] = m_act[i];
        return v;
    endfunction

    function automatic logic [2:0] ex_typ();
        logic [2:0] v;
        for (int i = 0; i < 3; i++) v[i] = m_typ[i];
        return v;
    endfunction

    function automatic int n_active();
        return int'(m_act[0]) + int'(m_act[1]) + int'(m_act[2]);
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_clk();
        #1;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        model_reset();
        #12;
        checks++;
        if (obstacle_active !== 3'd0) $display("FAIL reset_active got %b want 000", obstacle_active);
        else passes++;
        checks++;
        if ({obstacle_type, obstacle_x} !== 33'd0) $display("FAIL reset_type_x got %h want 0", {obstacle_type, obstacle_x});
        else passes++;
        checks++;
        if (spawn_pulse !== 1'b0) $display("FAIL reset_pulse got %b want 0", spawn_pulse);
        else passes++;
        checks++;
        if (dut.gap_cnt !== 10'd160) $display("FAIL reset_gap got %0d want 160", dut.gap_cnt);
        else passes++;
        @(negedge clk);
        sys_rst = 1'b0;
        cyc();
        step = 1'b1;
        repeat (5) cyc();
        checks++;
        if ({obstacle_active, dut.gap_cnt} !== {3'd0, 10'd160})
            $display("FAIL idle_ignores_step got %b/%0d want 000/160", obstacle_active, dut.gap_cnt);
        else passes++;
        step = 1'b0;
    endtask

    task automatic test_first_spawn();
        int pulses = 0;
        rnd = 8'd0;
        start = 1'b1;
        step = 1'b0;
        cyc();
        step = 1'b1;
        for (int i = 0; i < 160; i++) begin
            cyc();
            if (spawn_pulse) pulses++;
        end
        checks++;
        if (pulses !== 0) $display("FAIL early_spawn got %0d pulses want 0", pulses);
        else passes++;
        checks++;
        if (dut.gap_cnt !== 10'd0) $display("FAIL gap_drained got %0d want 0", dut.gap_cnt);
        else passes++;
        cyc();
        checks++;
        if ({spawn_pulse, obstacle_active, obstacle_type[0], obstacle_x[9:0]} !== {1'b1, 3'b001, 1'b0, 10'd639})
            $display("FAIL first_spawn got p=%b a=%b t=%b x=%0d want p=1 a=001 t=0 x=639",
                     spawn_pulse, obstacle_active, obstacle_type[0], obstacle_x[9:0]);
        else passes++;
        checks++;
        if (dut.gap_cnt !== 10'd160) $display("FAIL first_reload got %0d want 160", dut.gap_cnt);
        else passes++;
        step = 1'b0;
        cyc();
        checks++;
        if (spawn_pulse !== 1'b0) $display("FAIL pulse_width got %b want 0", spawn_pulse);
        else passes++;
        step = 1'b1;
        repeat (639) cyc();
        checks++;
        if ({obstacle_active[0], obstacle_x[9:0]} !== {1'b1, 10'd0})
            $display("FAIL slot0_at_zero got a=%b x=%0d want a=1 x=0", obstacle_active[0], obstacle_x[9:0]);
        else passes++;
        cyc();
        checks++;
        if (obstacle_active[0] !== 1'b0) $display("FAIL slot0_retire got %b want 0", obstacle_active[0]);
        else passes++;
        checks++;
        if ({obstacle_active, obstacle_type, obstacle_x} !== {ex_act(), ex_typ(), ex_x()})
            $display("FAIL model_after_retire got %b %h want %b %h", obstacle_active, obstacle_x, ex_act(), ex_x());
        else passes++;
    endtask

    task automatic test_full_slots();
        bit found = 0;
        int j;
        step = 1'b1;
        rnd = 8'd0;
        for (int k = 0; k < 3000 && !found; k++) begin
            j = -1;
            if (n_active() == 3 && m_gap == 0)
                for (int i = 0; i < 3; i++) if (m_x[i] == 0) j = i;
            cyc();
            if (j >= 0) begin
                found = 1;
                checks++;
                if ({spawn_pulse, obstacle_active[j]} !== 2'b00)
                    $display("FAIL retire_no_spawn slot %0d got p=%b a=%b want 0 0", j, spawn_pulse, obstacle_active[j]);
                else passes++;
                cyc();
                checks++;
                if ({spawn_pulse, obstacle_active[j], obstacle_x[j*10 +: 10]} !== {1'b1, 1'b1, 10'd639})
                    $display("FAIL spawn_after_free slot %0d got p=%b a=%b x=%0d want 1 1 639",
                             j, spawn_pulse, obstacle_active[j], obstacle_x[j*10 +: 10]);
                else passes++;
            end
        end
        if (!found) begin
            checks++;
            $display("FAIL full_slots_timeout got none want full-slot retire event");
        end
    endtask

    task automatic test_halt();
        step = 1'b1;
        repeat (37) cyc();
        halt = 1'b1;
        step = 1'b0;
        cyc();
        step = 1'b1;
        repeat (50) cyc();
        checks++;
        if (obstacle_x !== ex_x()) $display("FAIL halt_x got %h want %h", obstacle_x, ex_x());
        else passes++;
        checks++;
        if (obstacle_active !== ex_act()) $display("FAIL halt_active got %b want %b", obstacle_active, ex_act());
        else passes++;
        checks++;
        if (dut.gap_cnt !== 10'(m_gap)) $display("FAIL halt_gap got %0d want %0d", dut.gap_cnt, m_gap);
        else passes++;
        halt = 1'b0;
        step = 1'b0;
        cyc();
        step = 1'b1;
        repeat (3) cyc();
        checks++;
        if ({obstacle_active, obstacle_x, dut.gap_cnt} !== {ex_act(), ex_x(), 10'(m_gap)})
            $display("FAIL resume got %b %h %0d want %b %h %0d",
                     obstacle_active, obstacle_x, dut.gap_cnt, ex_act(), ex_x(), m_gap);
        else passes++;
    endtask

    task automatic test_game_rst();
        bit found = 0;
        step = 1'b1;
        for (int k = 0; k < 3000 && !found; k++) begin
            cyc();
            if (n_active() == 2) found = 1;
        end
        checks++;
        if (obstacle_active !== ex_act() || !found)
            $display("FAIL two_active got %b want %b", obstacle_active, ex_act());
        else passes++;
        game_rst = 1'b1;
        start = 1'b1;
        cyc();
        game_rst = 1'b0;
        checks++;
        if ({obstacle_active, spawn_pulse, dut.gap_cnt} !== {3'd0, 1'b0, 10'd160})
            $display("FAIL game_rst got a=%b p=%b g=%0d want 000 0 160", obstacle_active, spawn_pulse, dut.gap_cnt);
        else passes++;
        start = 1'b0;
        repeat (5) cyc();
        checks++;
        if ({obstacle_active, dut.gap_cnt} !== {3'd0, 10'd160})
            $display("FAIL game_rst_idle got a=%b g=%0d want 000 160", obstacle_active, dut.gap_cnt);
        else passes++;
        // restart abort just as a spawn is due
        start = 1'b1;
        found = 0;
        for (int k = 0; k < 1000 && !found; k++) begin
            if (m_st == 1 && m_gap == 0 && n_active() < 3) found = 1;
            else cyc();
        end
        game_rst = 1'b1;
        cyc();
        game_rst = 1'b0;
        start = 1'b0;
        checks++;
        if ({found, obstacle_active, spawn_pulse} !== {1'b1, 3'd0, 1'b0})
            $display("FAIL game_rst_mid_spawn got f=%b a=%b p=%b want 1 000 0", found, obstacle_active, spawn_pulse);
        else passes++;
        // asynchronous reset at the same point
        start = 1'b1;
        found = 0;
        for (int k = 0; k < 1000 && !found; k++) begin
            if (m_st == 1 && m_gap == 0 && n_active() < 3) found = 1;
            else cyc();
        end
        sys_rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        sys_rst = 1'b0;
        checks++;
        if ({found, obstacle_active, spawn_pulse} !== {1'b1, 3'd0, 1'b0})
            $display("FAIL sys_rst_mid_spawn got f=%b a=%b p=%b want 1 000 0", found, obstacle_active, spawn_pulse);
        else passes++;
        start = 1'b0;
        step = 1'b0;
    endtask

    task automatic test_random();
        int bad = 0;
        game_rst = 1'b1;
        cyc();
        game_rst = 1'b0;
        for (int k = 0; k < 8000; k++) begin
            start = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 99) < 3) halt = ~halt;
            step = ($urandom_range(0, 3) != 0);
            rnd = 8'($urandom);
            game_rst = ($urandom_range(0, 2999) == 0);
            cyc();
            checks++;
            if ({obstacle_active, obstacle_type, obstacle_x, spawn_pulse, dut.gap_cnt} !==
                {ex_act(), ex_typ(), ex_x(), m_sp, 10'(m_gap)}) begin
                bad++;
                if (fail_prints < 10) begin
                    fail_prints++;
                    $display("FAIL random_cycle %0d got a=%b t=%b x=%h p=%b g=%0d want a=%b t=%b x=%h p=%b g=%0d",
                             k, obstacle_active, obstacle_type, obstacle_x, spawn_pulse, dut.gap_cnt,
                             ex_act(), ex_typ(), ex_x(), m_sp, m_gap);
                end
            end else passes++;
        end
        game_rst = 1'b0;
        halt = 1'b0;
        step = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_speedup();
        int n = 0;
        int e;
        game_rst = 1'b1;
        cyc();
        game_rst = 1'b0;
        rnd = 8'd0;
        start = 1'b1;
        halt = 1'b0;
        step = 1'b1;
        for (int k = 0; k < 40000 && n < 100; k++) begin
            cyc();
            if (m_sp) begin
                n++;
`ifdef OBSTACLE_SPEEDUP_EN
                e = 160 - 16 * ((n - 1) / 16);
                if (e < 64) e = 64;
`else
                e = 160;
`endif
                checks++;
                if ({spawn_pulse, dut.gap_cnt} !== {1'b1, 10'(e)}) begin
                    if (fail_prints < 20) begin
                        fail_prints++;
                        $display("FAIL reload_spawn%0d got p=%b g=%0d want p=1 g=%0d", n, spawn_pulse, dut.gap_cnt, e);
                    end
                end else passes++;
            end
        end
        checks++;
        if (n !== 100) $display("FAIL speedup_spawns got %0d want 100", n);
        else passes++;
        step = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_first_spawn();
        test_full_slots();
        test_halt();
        test_game_rst();
        test_random();
        test_speedup();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
